// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped console transmit FIFO and free-running cycle counter.
// Loads are combinational from aluout; stores and FIFO/counter updates happen on the rising edge.
module dmem_mmio #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    // Word addresses (byte address >> 2) of the MMIO registers.
    localparam logic [29:0] ConsoleDataW   = 30'h3FFF_C000;
    localparam logic [29:0] ConsoleStatusW = 30'h3FFF_C001;
    localparam logic [29:0] CycleW         = 30'h3FFF_C002;

    logic [31:0]    mem [RAM_WORDS];
    logic [7:0]     fifo_q [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [31:0]    cycle_q, cycle_d;

    logic [29:0]    word_addr;
    logic [AW-1:0]  ram_idx;
    logic           sel_ram, sel_data, sel_status, sel_cycle;
    logic           full, empty, pop, push_req, push;
    logic           unused_byte_offset;

    assign word_addr  = aluout[31:2];
    assign ram_idx    = aluout[AW+1:2];
    assign sel_ram    = (aluout[31:AW+2] == '0);
    assign sel_data   = (word_addr == ConsoleDataW);
    assign sel_status = (word_addr == ConsoleStatusW);
    assign sel_cycle  = (word_addr == CycleW);

    assign unused_byte_offset = ^aluout[1:0];

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign tx_valid = ~empty;
    assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

    assign pop      = tx_valid & tx_ready;
    assign push_req = memwrite & sel_data;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign push     = push_req & (~full | pop);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        cycle_d    = cycle_q + 32'd1;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over clear.
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end else if (memwrite && sel_status) begin
            overflow_d = 1'b0;
        end

        if (memwrite && sel_cycle) begin
            cycle_d = writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cycle_q    <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cycle_q    <= cycle_d;
        end
    end

    // Storage arrays are not reset; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && memwrite && sel_ram) begin
            mem[ram_idx] <= writedata;
        end
        if (!reset && push) begin
            fifo_q[wr_ptr_q] <= writedata[7:0];
        end
    end

    always_comb begin
        readdata = 32'h0;
        if (sel_ram) begin
            readdata = mem[ram_idx];
        end else if (sel_status) begin
            readdata = {29'b0, overflow_q, empty, full};
        end else if (sel_cycle) begin
            readdata = cycle_q;
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM, console FIFO, status and cycle counter.
module tb_dmem_mmio;

    localparam logic [31:0] AddrData   = 32'hFFFF_0000;
    localparam logic [31:0] AddrStatus = 32'hFFFF_0004;
    localparam logic [31:0] AddrCycle  = 32'hFFFF_0008;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks;
    int n_fail;

    dmem_mmio #(
        .RAM_WORDS (64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .aluout   (aluout),
        .writedata(writedata),
        .readdata (readdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Store is applied for one edge; returns at posedge+1 with memwrite dropped.
    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        memwrite  = 1'b1;
        aluout    = addr;
        writedata = data;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        aluout = addr;
        #1;
        data = readdata;
    endtask

    logic [31:0] rd;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        memwrite  = 1'b0;
        aluout    = 32'h0;
        writedata = 32'h0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and cycle counter
        check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_eq("rst_tx_data", {24'b0, tx_data}, 32'h0);
        bus_rd(AddrCycle, rd);
        check_eq("rst_cycle", rd, 32'h0);
        bus_rd(AddrStatus, rd);
        check_eq("rst_status", rd, 32'h2);
        repeat (10) @(posedge clk);
        #1;
        bus_rd(AddrCycle, rd);
        check_eq("cycle_10", rd, 32'd10);
        bus_wr(AddrCycle, 32'hFFFF_FFFE);
        bus_rd(AddrCycle, rd);
        check_eq("cycle_load", rd, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        bus_rd(AddrCycle, rd);
        check_eq("cycle_max", rd, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        bus_rd(AddrCycle, rd);
        check_eq("cycle_wrap", rd, 32'h0);

        // RAM, byte offset ignored, out-of-range and unmapped reads
        bus_wr(32'h0000_0010, 32'hDEAD_BEEF);
        bus_rd(32'h0000_0013, rd);
        check_eq("ram_rd_offset", rd, 32'hDEAD_BEEF);
        bus_rd(32'h0000_0100, rd);
        check_eq("ram_out_of_range", rd, 32'h0);
        bus_rd(32'hFFFF_000C, rd);
        check_eq("unmapped_rd", rd, 32'h0);
        bus_wr(32'h0000_0014, 32'h1111_1111);
        memwrite  = 1'b1;
        aluout    = 32'h0000_0014;
        writedata = 32'h2222_2222;
        #1;
        check_eq("ram_read_before_write", readdata, 32'h1111_1111);
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        check_eq("ram_after_write", readdata, 32'h2222_2222);

        // FIFO fill, overflow, drain, clear
        tx_ready  = 1'b0;
        memwrite  = 1'b1;
        aluout    = AddrData;
        writedata = 32'h0000_0041;
        #1;
        check_eq("no_bypass", {31'b0, tx_valid}, 32'h0);
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        check_eq("valid_after_push", {31'b0, tx_valid}, 32'h1);
        for (int i = 1; i < 4; i++) bus_wr(AddrData, 32'h41 + i);
        bus_rd(AddrStatus, rd);
        check_eq("status_full", rd, 32'h1);
        bus_rd(AddrData, rd);
        check_eq("data_reads_zero", rd, 32'h0);
        bus_wr(AddrData, 32'h0000_0045);
        bus_rd(AddrStatus, rd);
        check_eq("status_full_ovf", rd, 32'h5);
        repeat (2) @(posedge clk);
        #1;
        check_eq("head_stable", {24'b0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_data", {24'b0, tx_data}, 32'h41 + i);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        bus_rd(AddrStatus, rd);
        check_eq("status_empty_ovf", rd, 32'h6);
        bus_wr(AddrStatus, 32'h0);
        bus_rd(AddrStatus, rd);
        check_eq("status_cleared", rd, 32'h2);

        // Push into full FIFO while popping
        for (int i = 0; i < 4; i++) bus_wr(AddrData, 32'h41 + i);
        tx_ready = 1'b1;
        bus_wr(AddrData, 32'h0000_0055);
        tx_ready = 1'b0;
        bus_rd(AddrStatus, rd);
        check_eq("full_push_pop_status", rd, 32'h1);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("full_push_pop_data", {24'b0, tx_data}, (i == 3) ? 32'h55 : 32'h42 + i);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        check_eq("drained_valid", {31'b0, tx_valid}, 32'h0);

        // Reset mid-queue: FIFO cleared, RAM kept, writes and pops suppressed
        bus_wr(32'h0000_0020, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) bus_wr(AddrData, 32'h61 + i);
        reset     = 1'b1;
        tx_ready  = 1'b1;
        memwrite  = 1'b1;
        aluout    = 32'h0000_0020;
        writedata = 32'h1234_5678;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        memwrite = 1'b0;
        tx_ready = 1'b0;
        check_eq("rst2_tx_valid", {31'b0, tx_valid}, 32'h0);
        bus_rd(AddrStatus, rd);
        check_eq("rst2_status", rd, 32'h2);
        bus_rd(AddrCycle, rd);
        check_eq("rst2_cycle", rd, 32'h0);
        bus_rd(32'h0000_0020, rd);
        check_eq("rst2_ram_kept", rd, 32'hCAFE_F00D);
        bus_rd(32'h0000_0010, rd);
        check_eq("rst2_ram_kept2", rd, 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
